sig_ram_fifo_ctrl: RTL and testbench
====================================

// Module: sig_ram_fifo_ctrl
// PURPOSE
//  Master side of the single-port RAM interface: turns a valid/ready stream into FIFO traffic on one shared
//  tri-state data bus (wren/addr/data). One RAM access per cycle; reads take 2 cycles, writes 1.
//  Holds a 1-word output register and presents first-word-fall-through to the consumer.
//  Sits between a producer stream and one single-port RAM instance; that RAM's rst_n is tied to ~rst.
// PARAMETERS
//  WIDTH  8    data width, must equal the RAM WIDTH
//  DEPTH  128  RAM words, must equal the RAM DEPTH; >=2; need not be a power of two
//  AW     $clog2(DEPTH)  address width (localparam)
// PORTS
//  clk        in     1        clock, rising edge
//  rst        in     1        asynchronous, active-high reset
//  in_valid   in     1        producer word valid
//  in_ready   out    1        controller accepts in_data this cycle
//  in_data    in     WIDTH    producer word
//  out_valid  out    1        out_data holds the oldest word
//  out_ready  in     1        consumer takes out_data
//  out_data   out    WIDTH    oldest word (registered)
//  ram_cnt    out    AW+1     words currently stored in RAM (0..DEPTH); excludes output register
//  ram_wren   out    1        RAM write enable (1 = write, 0 = read/idle)
//  ram_addr   out    AW       RAM address
//  ram_data   inout  WIDTH    shared bus: driven with write data only while ram_wren=1, else 'z
// BEHAVIOUR
//  Reset (async, any time incl. mid-read): phase=ACCESS, wr_ptr=rd_ptr=0, ram_cnt=0, out_valid=0,
//   out_data=0, ram_wren=0, ram_addr=0, ram_data='z. RAM contents are not cleared; queued data is lost.
//  Registered phase FSM, two states:
//   ACCESS : if (!out_valid && ram_cnt!=0) -> READ ISSUE: ram_wren=0, ram_addr=rd_ptr, in_ready=0;
//              next=RD_DATA.
//            else in_ready=(ram_cnt<DEPTH); on in_valid&&in_ready -> WRITE: ram_wren=1, ram_addr=wr_ptr,
//              ram_data=in_data, wr_ptr++, ram_cnt++; stays ACCESS. Else idle: ram_wren=0, addr=rd_ptr.
//   RD_DATA: ram_wren=0, ram_addr=rd_ptr, in_ready=0; at edge out_data<=ram_data, out_valid<=1,
//              rd_ptr++, ram_cnt--; next=ACCESS.
//  Read priority: an empty output register with data in RAM always wins over a pending write.
//  in_ready depends on registered state only: no combinational in_valid->in_ready path.
//  Bus rule: controller drives ram_data only when ram_wren=1; RAM drives it when ram_wren=0. Never both.
//  Read data is the RAM registered output: valid on the bus in the cycle after issue with ram_wren still 0,
//   hence the mandatory RD_DATA cycle.
//  Output: out_valid&&out_ready clears out_valid at edge. Read issue uses registered out_valid, so a pop
//   cycle does not itself issue a read; the read follows in the next ACCESS cycle.
//  Pointers wrap DEPTH-1 -> 0 by explicit compare. ram_cnt==DEPTH: in_ready=0. ram_cnt==0: no read issued.
//  Write then read of the same address in consecutive cycles returns the new data (write lands at edge).
//  Latency (no bypass): word accepted cycle N -> read issue N+1 -> RD_DATA N+2 -> out_valid=1 in N+3.
//  Capacity: DEPTH+1 words (RAM + output register).
// CONFIGURATION
//  FIFO_BYPASS_EN defined: in ACCESS with ram_cnt==0 && !out_valid, in_ready=1 and an accepted word
//   loads out_data directly (out_valid=1 next cycle, latency 1); no RAM access, ram_wren=0.
//  FIFO_BYPASS_EN undefined: every word passes through RAM; latency 3 as above.
// TESTING
//  1 rst pulse during RD_DATA -> same cycle ram_wren=0, ram_data='z, out_valid=0; after release ram_cnt=0, in_ready=1.
//  2 push 0x11,0x22,0x33 back-to-back, out_ready=0 -> out_data=0x11, out_valid=1 3 cycles after first
//    accept; ram_cnt ends at 2; ram_wren low in the 2 read cycles.
//  3 DEPTH=4, out_ready=0, push until in_ready=0 -> exactly 5 words accepted, ram_cnt=4; then drain -> same order.
//  4 DEPTH=4, stream 10 words 0x00..0x09 with random out_ready -> output order intact across 2 pointer wraps.
//  5 ram_cnt=2, out_valid=0, in_valid=1 -> read issued, in_ready=0 that cycle and in RD_DATA; write next.
//  6 assertion all tests: never ram_wren=0 with controller driving ram_data; FIFO_BYPASS_EN build: push 0xA5
//    into empty FIFO -> out_valid=1 next cycle, out_data=0xA5, no ram_wren pulse.

Source files
------------

// File: rtl/sig_ram_fifo_ctrl.sv
// sig_ram_fifo_ctrl
//   Master side of a single-port RAM FIFO. A producer valid/ready stream
//   is queued in an external single-port RAM over a shared tri-state data
//   bus. A one-word output register gives first-word-fall-through to the
//   consumer. Reads take two cycles (issue + data) and writes take one.
//   Capacity is DEPTH+1 words: the RAM plus the output register.
//
//   Build option: define FIFO_BYPASS_EN so that a word arriving at a
//   completely empty FIFO is loaded straight into the output register,
//   without a RAM access.
//
// Parameters
//   WIDTH     data width (equal to the RAM width)
//   DEPTH     number of RAM words (>=2, any value)
//   AW        address width, $clog2(DEPTH)
// Ports
//   clk, rst  clock (rising edge), asynchronous active-high reset
//   in_*      producer stream (in_ready depends only on registered state)
//   out_*     consumer stream; out_data is registered
//   ram_cnt   number of words held in RAM (excludes the output register)
//   ram_wren  RAM write enable (1 = write, 0 = read or idle)
//   ram_addr  RAM address
//   ram_data  shared bus; driven here only while ram_wren=1
module sig_ram_fifo_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 128,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW:0]      ram_cnt,
  output logic             ram_wren,
  output logic [AW-1:0]    ram_addr,
  inout  wire  [WIDTH-1:0] ram_data
);

  localparam int unsigned CW = AW + 1;

  typedef enum logic {
    ACCESS  = 1'b0,
    RD_DATA = 1'b1
  } phase_t;

  phase_t           phase_q, phase_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ov_q, ov_d;
  logic [WIDTH-1:0] od_q, od_d;

  logic [AW-1:0]    wr_ptr_inc;
  logic [AW-1:0]    rd_ptr_inc;
  logic             ram_full;
  logic             ram_empty;

  // Pointer increments wrap explicitly so DEPTH need not be a power of two
  assign wr_ptr_inc = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
  assign rd_ptr_inc = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
  assign ram_full   = (cnt_q == CW'(DEPTH));
  assign ram_empty  = (cnt_q == '0);

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= ACCESS;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ov_q     <= 1'b0;
      od_q     <= '0;
    end else begin
      phase_q  <= phase_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ov_q     <= ov_d;
      od_q     <= od_d;
    end
  end

  // Next state, RAM command and handshake
  always_comb begin
    phase_d  = phase_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ov_d     = ov_q;
    od_d     = od_q;
    in_ready = 1'b0;
    ram_wren = 1'b0;
    ram_addr = rd_ptr_q;

    // Consumer pop frees the output register at the edge
    if (ov_q && out_ready) begin
      ov_d = 1'b0;
    end

    unique case (phase_q)
      ACCESS: begin
        if (!ov_q && !ram_empty) begin
          // Refilling an empty output register beats any pending write
          phase_d = RD_DATA;
        end else begin
          in_ready = !ram_full;
          if (in_valid && !ram_full) begin
`ifdef FIFO_BYPASS_EN
            if (ram_empty && !ov_q) begin
              od_d = in_data;
              ov_d = 1'b1;
            end else begin
              ram_wren = 1'b1;
              ram_addr = wr_ptr_q;
              wr_ptr_d = wr_ptr_inc;
              cnt_d    = cnt_q + CW'(1);
            end
`else
            ram_wren = 1'b1;
            ram_addr = wr_ptr_q;
            wr_ptr_d = wr_ptr_inc;
            cnt_d    = cnt_q + CW'(1);
`endif
          end
        end
      end
      RD_DATA: begin
        // RAM output register presents the word issued last cycle
        od_d     = ram_data;
        ov_d     = 1'b1;
        rd_ptr_d = rd_ptr_inc;
        cnt_d    = cnt_q - CW'(1);
        phase_d  = ACCESS;
      end
      default: begin
        phase_d = ACCESS;
      end
    endcase

    // Keep the bus released and the producer stalled while reset is held
    if (rst) begin
      in_ready = 1'b0;
      ram_wren = 1'b0;
    end
  end

  // The controller owns the bus only during a write
  assign ram_data  = ram_wren ? in_data : {WIDTH{1'bz}};

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign ram_cnt   = cnt_q;

endmodule

// File: tb/tb_sig_ram_fifo_ctrl.sv
// Testbench for sig_ram_fifo_ctrl: single-port RAM model on the shared bus,
// queue reference model of FIFO order and occupancy, directed and random
// stimulus. Define FIFO_BYPASS_EN to exercise the bypass build.
module tb_sig_ram_fifo_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;
`ifdef FIFO_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 3;
`endif

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [AW:0]      ram_cnt;
  logic             ram_wren;
  logic [AW-1:0]    ram_addr;
  wire  [WIDTH-1:0] ram_data;

  sig_ram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .ram_cnt  (ram_cnt),
    .ram_wren (ram_wren),
    .ram_addr (ram_addr),
    .ram_data (ram_data)
  );

  // Single-port RAM with registered read output; drives the bus when not written
  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [WIDTH-1:0] ram_q;
  always @(posedge clk or posedge rst) begin
    if (rst) ram_q <= '0;
    else if (ram_wren) mem[ram_addr] <= ram_data;
    else ram_q <= mem[ram_addr];
  end
  assign ram_data = (!ram_wren && !rst) ? ram_q : {WIDTH{1'bz}};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [WIDTH-1:0] q[$];
  bit ov_hist [0:16383];
  bit ir_hist [0:16383];
  bit we_hist [0:16383];
  bit s_acc, s_pop, s_rdiss;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample handshakes before the edge, update the model, land on the next negedge
  task automatic cycle();
    logic [WIDTH-1:0] exp_w;
    int exp_cnt;
    #1;
    s_acc   = in_valid && in_ready;
    s_pop   = out_valid && out_ready;
    s_rdiss = !out_valid && !in_ready && (ram_cnt != '0);
    ov_hist[cyc] = out_valid;
    ir_hist[cyc] = in_ready;
    we_hist[cyc] = ram_wren;
    if (ram_wren) begin
      check("bus_wr_data", 32'(ram_data), 32'(in_data));
      check("wr_has_accept", 32'(s_acc), 32'd1);
    end else begin
      check("bus_ram_owned", 32'(ram_data), 32'(ram_q));
    end
    if (q.size() == DEPTH + 1) check("full_ready_low", 32'(in_ready), 32'd0);
    if (s_pop) begin
      exp_w = q.pop_front();
      check("out_order", 32'(out_data), 32'(exp_w));
    end
    if (s_acc) q.push_back(in_data);
    @(negedge clk);
    cyc++;
    exp_cnt = q.size() - (out_valid ? 1 : 0);
    check("ram_cnt", 32'(ram_cnt), 32'(exp_cnt));
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    @(negedge clk);
    q.delete();
    rst = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (q.size() != 0 && g < 200) begin
      cycle();
      g++;
    end
    check("drain_empty", 32'(q.size()), 32'd0);
    check("drain_ov", 32'(out_valid), 32'd0);
    check("drain_cnt", 32'(ram_cnt), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] w2 [0:2];
    int n, first, guard, p, acc, popped, pushed;
    bit found;
    w2[0] = 8'h11; w2[1] = 8'h22; w2[2] = 8'h33;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #2;
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_wren", 32'(ram_wren), 32'd0);
    check("rst_cnt", 32'(ram_cnt), 32'd0);
    check("rst_odata", 32'(out_data), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_rel_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Back-to-back push of three words with the consumer stalled
    do_reset();
    in_valid = 1'b1; first = -1; n = 0; guard = 0;
    while (n < 3 && guard < 40) begin
      in_data = w2[n];
      cycle();
      if (s_acc) begin
        if (first < 0) first = cyc - 1;
        n++;
      end
      guard++;
    end
    in_valid = 1'b0;
    check("t2_accepted", 32'(n), 32'd3);
    repeat (2) cycle();
    if (first >= 0) begin
      check("t2_ov_before", 32'(ov_hist[first + LAT - 1]), 32'd0);
      check("t2_ov_latency", 32'(ov_hist[first + LAT]), 32'd1);
`ifndef FIFO_BYPASS_EN
      check("t2_wren_issue", 32'(we_hist[first + 1]), 32'd0);
      check("t2_wren_rddata", 32'(we_hist[first + 2]), 32'd0);
      check("t2_ready_issue", 32'(ir_hist[first + 1]), 32'd0);
      check("t2_ready_rddata", 32'(ir_hist[first + 2]), 32'd0);
`endif
    end
    check("t2_out_data", 32'(out_data), 32'h11);
    check("t2_ram_cnt", 32'(ram_cnt), 32'd2);

    // Read priority over a pending write
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    check("t5_ov_empty", 32'(out_valid), 32'd0);
    check("t5_cnt", 32'(ram_cnt), 32'd2);
    in_valid = 1'b1; in_data = 8'h44; p = cyc;
    cycle();
    check("t5_issue_ready", 32'(ir_hist[p]), 32'd0);
    check("t5_issue_wren", 32'(we_hist[p]), 32'd0);
    cycle();
    check("t5_rddata_ready", 32'(ir_hist[p + 1]), 32'd0);
    cycle();
    check("t5_write_next", 32'(we_hist[p + 2]), 32'd1);
    check("t5_accept_next", 32'(s_acc), 32'd1);
    drain();

    // Capacity: DEPTH words in RAM plus one in the output register
    do_reset();
    in_valid = 1'b1; acc = 0;
    for (int i = 0; i < 30; i++) begin
      in_data = 8'($urandom);
      cycle();
      if (s_acc) acc++;
    end
    in_valid = 1'b0;
    check("t3_accepted", 32'(acc), 32'(DEPTH + 1));
    check("t3_cnt_full", 32'(ram_cnt), 32'(DEPTH));
    check("t3_ready_low", 32'(in_ready), 32'd0);
    check("t3_ov", 32'(out_valid), 32'd1);
    drain();

    // Stream 0..9 with a random consumer; pointers wrap twice
    n = 0; popped = 0; guard = 0;
    while (popped < 10 && guard < 400) begin
      in_valid  = (n < 10);
      in_data   = 8'(n);
      out_ready = 1'($urandom % 2);
      cycle();
      if (s_acc) n++;
      if (s_pop) popped++;
      guard++;
    end
    check("t4_popped", 32'(popped), 32'd10);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom % 2);
      in_data   = 8'($urandom);
      out_ready = 1'(($urandom % 4) != 0);
      cycle();
    end
    drain();

    // Reset pulse while a read is in its data cycle
    do_reset();
    out_ready = 1'b1; pushed = 0; found = 1'b0; guard = 0;
    while (!found && guard < 20) begin
      in_valid = (pushed < 2);
      in_data  = 8'h5A + 8'(pushed);
      cycle();
      if (s_acc) pushed++;
      if (s_rdiss) found = 1'b1;
      guard++;
    end
    check("t1_read_seen", 32'(found), 32'd1);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("t1_rst_wren", 32'(ram_wren), 32'd0);
    check("t1_rst_ov", 32'(out_valid), 32'd0);
    check("t1_rst_cnt", 32'(ram_cnt), 32'd0);
    @(negedge clk);
    q.delete();
    rst = 1'b0;
    #1;
    check("t1_rel_cnt", 32'(ram_cnt), 32'd0);
    check("t1_rel_ready", 32'(in_ready), 32'd1);
    check("t1_rel_ov", 32'(out_valid), 32'd0);
    @(negedge clk);

`ifdef FIFO_BYPASS_EN
    // Bypass of an empty FIFO
    do_reset();
    in_valid = 1'b1; in_data = 8'hA5; p = cyc;
    cycle();
    in_valid = 1'b0;
    check("t6_accept", 32'(s_acc), 32'd1);
    check("t6_no_wren", 32'(we_hist[p]), 32'd0);
    check("t6_ov", 32'(out_valid), 32'd1);
    check("t6_data", 32'(out_data), 32'hA5);
    check("t6_cnt", 32'(ram_cnt), 32'd0);
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
